// File: rtl/mem_burst_ctrl_pkg.sv
// Shared types and constants for the burst controller in front of the single-port memory.
package mem_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// Command, write-stream, read-stream and memory-side signals of the burst controller.
// "master" is the controller's view (it masters the memory); "slave" is the surrounding system.
interface mem_burst_ctrl_if #(
  parameter int DATA_LENGTH = 32,
  parameter int ADDR_SIZE   = 4,
  parameter int LEN_W       = ADDR_SIZE + 1
);

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_wr_rd;
  logic [ADDR_SIZE-1:0]   cmd_addr;
  logic [LEN_W-1:0]       cmd_len;

  logic                   wr_valid;
  logic [DATA_LENGTH-1:0] wr_data;
  logic                   wr_ready;

  logic                   rd_valid;
  logic [DATA_LENGTH-1:0] rd_data;
  logic                   rd_ready;

  logic                   mem_valid;
  logic                   mem_wr_rd;
  logic [ADDR_SIZE-1:0]   mem_addr;
  logic [DATA_LENGTH-1:0] mem_wdata;
  logic [DATA_LENGTH-1:0] mem_rdata;
  logic                   mem_ready;

  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    input  cmd_valid, cmd_wr_rd, cmd_addr, cmd_len,
    output cmd_ready,
    input  wr_valid, wr_data,
    output wr_ready,
    output rd_valid, rd_data,
    input  rd_ready,
    output mem_valid, mem_wr_rd, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_wr_rd, cmd_addr, cmd_len,
    input  cmd_ready,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rd_valid, rd_data,
    output rd_ready,
    input  mem_valid, mem_wr_rd, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  busy, done, err
  );

endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst controller: turns one command into a sequence of single memory accesses,
// with address wrap, read back-pressure and a ready-timeout watchdog.
module mem_burst_ctrl
  import mem_burst_pkg::*;
#(
  parameter int DATA_LENGTH = 32,
  parameter int ADDR_SIZE   = 4,
  parameter int LEN_W       = ADDR_SIZE + 1,
  parameter int TIMEOUT     = 15
) (
  input  logic               clk,
  input  logic               rst,
  mem_burst_ctrl_if.master   bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_e                 state_q, state_d;
  logic                   dir_q, dir_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]       remain_q, remain_d;
  logic [WD_W-1:0]        wdog_q, wdog_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [DATA_LENGTH-1:0] rd_data_q, rd_data_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   busy_q;

  logic                   rd_slot_free_s;
  logic                   issue_fire_s;

  // Fire qualification: a read may only issue once the output register can take the beat
  always_comb begin
    rd_slot_free_s = 1'b0;
    issue_fire_s   = 1'b0;
    if (!rd_valid_q || bus.rd_ready) begin
      rd_slot_free_s = 1'b1;
    end else begin
      rd_slot_free_s = 1'b0;
    end
    if (state_q == ISSUE) begin
      if (dir_q == WR) begin
        issue_fire_s = bus.wr_valid;
      end else begin
        issue_fire_s = rd_slot_free_s;
      end
    end else begin
      issue_fire_s = 1'b0;
    end
  end

  // Next-state and datapath updates of the burst sequencer
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    wdog_d     = wdog_q;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    err_d      = err_q;
    // Draining the output register; a capture below overrides this
    if (rd_valid_q && bus.rd_ready) begin
      rd_valid_d = 1'b0;
    end else begin
      rd_valid_d = rd_valid_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          dir_d    = bus.cmd_wr_rd;
          addr_d   = bus.cmd_addr;
          remain_d = bus.cmd_len;
          err_d    = 1'b0;
          if (bus.cmd_len == {LEN_W{1'b0}}) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = ISSUE;
          end
        end else begin
          state_d = IDLE;
        end
      end

      ISSUE: begin
        if (issue_fire_s) begin
          wdog_d  = {WD_W{1'b0}};
          state_d = WAIT;
        end else begin
          state_d = ISSUE;
        end
      end

      WAIT: begin
        if (bus.mem_ready) begin
          if (dir_q == RD) begin
            rd_data_d  = bus.mem_rdata;
            rd_valid_d = 1'b1;
          end else begin
            rd_data_d  = rd_data_q;
          end
          addr_d   = addr_q + ADDR_SIZE'(1);
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = ISSUE;
          end
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wdog_d  = wdog_q + WD_W'(1);
          state_d = WAIT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      addr_q     <= {ADDR_SIZE{1'b0}};
      remain_q   <= {LEN_W{1'b0}};
      wdog_q     <= {WD_W{1'b0}};
      rd_valid_q <= 1'b0;
      rd_data_q  <= {DATA_LENGTH{1'b0}};
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      wdog_q     <= wdog_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.mem_valid = issue_fire_s;
  assign bus.wr_ready  = issue_fire_s && (dir_q == WR);
  assign bus.mem_wr_rd = dir_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = bus.wr_data;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Randomised scoreboard bench for mem_burst_ctrl with a behavioural single-port memory.
module tb_mem_burst_ctrl;
  import mem_burst_pkg::*;

  localparam int DL = 32;
  localparam int AS = 4;
  localparam int LW = 5;
  localparam int TO = 15;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;

  mem_burst_ctrl_if #(.DATA_LENGTH(DL), .ADDR_SIZE(AS), .LEN_W(LW)) bus ();

  mem_burst_ctrl #(.DATA_LENGTH(DL), .ADDR_SIZE(AS), .LEN_W(LW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AS-1:0] addr;
    logic [DL-1:0] data;
  } acc_t;

  acc_t          exp_acc_q[$];
  logic [DL-1:0] exp_rd_q[$];
  logic          exp_done_q[$];
  logic [DL-1:0] wr_q[$];
  int            fire_cyc_q[$];

  logic [DL-1:0] mem[DEPTH];
  logic [DL-1:0] ref_mem[DEPTH];
  logic [DL-1:0] held;
  bit            mem_init_done = 1'b0;
  int            pend = 0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fire_cnt = 0;
  int last_fire_cyc = 0;
  bit wr_hold, bp_low, mem_stuck;
  int mem_lat;

  task automatic check(input string name, input logic [DL-1:0] act, input logic [DL-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural sp_memory: ready one cycle, mem_lat cycles after the valid cycle
  always @(posedge clk) begin
    bus.mem_ready <= 1'b0;
    if (!mem_init_done) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
      mem_init_done <= 1'b1;
    end else if (bus.mem_valid === 1'b1 && !mem_stuck) begin
      if (bus.mem_wr_rd) mem[bus.mem_addr] <= bus.mem_wdata;
      if (mem_lat == 0) begin
        bus.mem_ready <= 1'b1;
        bus.mem_rdata <= mem[bus.mem_addr];
      end else begin
        pend <= mem_lat;
        held <= mem[bus.mem_addr];
      end
    end else if (pend > 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        bus.mem_ready <= 1'b1;
        bus.mem_rdata <= held;
      end
    end
  end

  initial begin : wr_driver
    forever begin
      @(posedge clk); #1;
      if (wr_q.size() > 0 && (wr_hold || $urandom_range(0, 3) != 0)) begin
        bus.wr_valid = 1'b1;
        bus.wr_data  = wr_q[0];
      end else begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = DL'($urandom);
      end
    end
  end

  initial begin : rd_driver
    forever begin
      @(posedge clk); #1;
      bus.rd_ready = bp_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : monitor
    acc_t a;
    logic e;
    logic [DL-1:0] r;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (bus.mem_valid === 1'b1) begin
          fire_cnt++;
          fire_cyc_q.push_back(cyc);
          last_fire_cyc = cyc;
          if (exp_acc_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL mem_unexpected: got access addr %0h expected none", bus.mem_addr);
          end else begin
            a = exp_acc_q.pop_front();
            check("mem_wr_rd", DL'(bus.mem_wr_rd), DL'(a.wr));
            check("mem_addr", DL'(bus.mem_addr), DL'(a.addr));
            if (a.wr) check("mem_wdata", bus.mem_wdata, a.data);
          end
        end
        if (bus.wr_valid === 1'b1 && bus.wr_ready === 1'b1 && wr_q.size() > 0) void'(wr_q.pop_front());
        if (bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) begin
          if (exp_rd_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL rd_unexpected: got beat %0h expected none", bus.rd_data);
          end else begin
            r = exp_rd_q.pop_front();
            check("rd_data", bus.rd_data, r);
          end
        end
        if (bus.done === 1'b1) begin
          if (exp_done_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL done_unexpected: got done=1 expected 0");
          end else begin
            e = exp_done_q.pop_front();
            check("done_err", DL'(bus.err), DL'(e));
            check("done_busy", DL'(bus.busy), 0);
            if (e) check("timeout_cycles", DL'(cyc - last_fire_cyc), DL'(TO + 1));
          end
        end
      end
    end
  end

  task automatic send_cmd(input bit wr, input int addr, input int len);
    int k;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_wr_rd = wr;
    bus.cmd_addr  = AS'(addr);
    bus.cmd_len   = LW'(len);
    k = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready", DL'(bus.cmd_ready), 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("err_clear_on_accept", DL'(bus.err), 0);
    if (len == 0) begin
      check("zero_len_done", DL'(bus.done), 1);
      check("zero_len_busy", DL'(bus.busy), 0);
    end else begin
      check("busy_after_accept", DL'(bus.busy), 1);
    end
  endtask

  // Reference: a burst touches addr, addr+1, ... modulo DEPTH; writes update the model memory
  task automatic issue_cmd(input bit wr, input int addr, input int len, input bit fixed_data);
    acc_t e;
    logic [DL-1:0] d;
    for (int i = 0; i < len; i++) begin
      e.addr = AS'((addr + i) % DEPTH);
      e.wr   = wr ? WR : RD;
      e.data = '0;
      if (wr) begin
        d = fixed_data ? DL'(32'hA0 + i) : DL'($urandom);
        wr_q.push_back(d);
        e.data = d;
        ref_mem[e.addr] = d;
      end else begin
        exp_rd_q.push_back(ref_mem[e.addr]);
      end
      exp_acc_q.push_back(e);
    end
    exp_done_q.push_back(1'b0);
    send_cmd(wr, addr, len);
  endtask

  task automatic wait_idle(input int budget, input bit need_rd);
    int k;
    k = 0;
    while ((exp_done_q.size() != 0 || (need_rd && exp_rd_q.size() != 0)) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (exp_done_q.size() != 0 || (need_rd && exp_rd_q.size() != 0)) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d done / %0d beats pending expected 0",
               exp_done_q.size(), exp_rd_q.size());
      exp_done_q.delete();
      exp_rd_q.delete();
      exp_acc_q.delete();
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    acc_t e;
    logic [DL-1:0] d;
    int f0, k;
    rst = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_wr_rd = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    wr_hold = 1'b0; bp_low = 1'b0; mem_stuck = 1'b0; mem_lat = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DL'($urandom);

    repeat (3) @(negedge clk);
    check("rst_busy", DL'(bus.busy), 0);
    check("rst_done", DL'(bus.done), 0);
    check("rst_err", DL'(bus.err), 0);
    check("rst_rd_valid", DL'(bus.rd_valid), 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_mem_valid", DL'(bus.mem_valid), 0);
    check("rst_mem_wr_rd", DL'(bus.mem_wr_rd), 0);
    check("rst_mem_addr", DL'(bus.mem_addr), 0);
    check("rst_cmd_ready", DL'(bus.cmd_ready), 1);
    rst = 1'b1;

    // Directed write of A0..A3 at 2, data held valid: one access every 2 cycles
    wr_hold = 1'b1;
    fire_cyc_q.delete();
    issue_cmd(1'b1, 2, 4, 1'b1);
    wait_idle(200, 1'b1);
    check("wr_fire_count", DL'(fire_cyc_q.size()), 4);
    for (int i = 0; i < 3 && i + 1 < fire_cyc_q.size(); i++)
      check("wr_fire_spacing", DL'(fire_cyc_q[i+1] - fire_cyc_q[i]), 2);
    wr_hold = 1'b0;
    issue_cmd(1'b0, 2, 4, 1'b0);
    wait_idle(300, 1'b1);

    // Address wrap 14,15,0,1
    issue_cmd(1'b0, 14, 4, 1'b0);
    wait_idle(300, 1'b1);

    // Back-pressure: first beat parked on rd_valid blocks further issue
    bp_low = 1'b1;
    issue_cmd(1'b0, 5, 3, 1'b0);
    k = 0;
    while (bus.rd_valid !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("bp_first_beat", DL'(bus.rd_valid), 1);
    f0 = fire_cnt;
    repeat (6) @(negedge clk);
    check("bp_no_issue", DL'(fire_cnt), DL'(f0));
    check("bp_beat_held", DL'(bus.rd_valid), 1);
    bp_low = 1'b0;
    wait_idle(300, 1'b1);

    // Watchdog: the memory never answers
    mem_stuck = 1'b1;
    e.wr = RD; e.addr = AS'(7); e.data = '0;
    exp_acc_q.push_back(e);
    exp_done_q.push_back(1'b1);
    send_cmd(1'b0, 7, 3);
    wait_idle(100, 1'b0);
    repeat (3) @(negedge clk);
    check("err_sticky", DL'(bus.err), 1);
    check("idle_after_abort", DL'(bus.cmd_ready), 1);
    mem_stuck = 1'b0;

    // Zero-length bursts in both directions; also clears err
    issue_cmd(1'b0, 3, 0, 1'b0);
    wait_idle(20, 1'b1);
    issue_cmd(1'b1, 9, 0, 1'b0);
    wait_idle(20, 1'b1);

    // Reset while waiting on beat 2 of a 4-beat write at 9
    wr_hold = 1'b1;
    mem_lat = 0;
    for (int i = 0; i < 4; i++) begin
      d = DL'($urandom);
      wr_q.push_back(d);
      e.wr = WR; e.addr = AS'(9 + i); e.data = d;
      exp_acc_q.push_back(e);
      if (i < 2) ref_mem[9 + i] = d;
    end
    exp_done_q.push_back(1'b0);
    f0 = fire_cnt;
    send_cmd(1'b1, 9, 4);
    k = 0;
    while (fire_cnt < f0 + 2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #2;
    rst = 1'b0;
    exp_acc_q.delete(); exp_done_q.delete(); wr_q.delete();
    #1;
    check("mid_rst_busy", DL'(bus.busy), 0);
    check("mid_rst_done", DL'(bus.done), 0);
    check("mid_rst_mem_valid", DL'(bus.mem_valid), 0);
    check("mid_rst_mem_addr", DL'(bus.mem_addr), 0);
    check("mid_rst_mem_wr_rd", DL'(bus.mem_wr_rd), 0);
    check("mid_rst_wr_ready", DL'(bus.wr_ready), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wr_hold = 1'b0;
    repeat (3) @(negedge clk);
    check("no_done_after_rst", DL'(bus.done), 0);
    issue_cmd(1'b0, 9, 4, 1'b0);
    wait_idle(300, 1'b1);

    // Randomised mix; reads may overlap a pending final beat of the previous burst
    for (int n = 0; n < 40; n++) begin
      mem_lat = $urandom_range(0, 3);
      wr_hold = $urandom_range(0, 1);
      issue_cmd($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 16), 1'b0);
      wait_idle(600, $urandom_range(0, 1));
    end
    wait_idle(600, 1'b1);
    check("acc_queue_empty", DL'(exp_acc_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
